dll_cfg_spi_target: RTL

- SPI mode-0 target that receives configuration frames driven onto the dedicated input pins by the external host (cocotb bench or board MCU) and returns read data on an output pin.
- Sits inside tt_um_dpetrisko_ttdll between the ui_in/uo_out pads and the DLL core.
- Holds the DLL configuration registers (delay-line trim, tap select, enables) and presents them as a flat bus.
- SPI inputs are asynchronous to clk, so they are oversampled: sclk must be slow relative to clk.

---
 rtl/dll_cfg_spi_target.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dll_cfg_spi_target.sv
// SPI mode-0 config target: oversampled pads, 16-bit frames {W, addr[6:0], data[7:0]}, flat cfg bus out.
// Write commits one clk after the synchronized 16th sclk rise; no backpressure (host paces via sclk).
module dll_cfg_spi_target #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk_i,
  input  logic                  spi_csn_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [8*NUM_REGS-1:0] cfg_o,
  output logic                  wr_pulse_o,
  output logic [6:0]            wr_addr_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic [SYNC_STAGES:0]   vld_q;

  state_e                     state_q, state_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [6:0]                 shift_q, shift_d;
  logic                       wr_q, wr_d;
  logic [6:0]                 addr_q, addr_d;
  logic [7:0]                 sout_q, sout_d;
  logic                       miso_q, miso_d;
  logic [NUM_REGS-1:0][7:0]   cfg_q, cfg_d;
  logic                       wr_pulse_q, wr_pulse_d;
  logic [6:0]                 wr_addr_q, wr_addr_d;
  logic                       err_q, err_d;

  logic       sclk_s, csn_s, mosi_s, smp_vld;
  logic       sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic [7:0] hdr, rd_byte;

  // vld_q marks when csn_prev_q holds a real pad sample, so the reset value
  // of the chain can never fake an edge into a frame already in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
      vld_q       <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
      vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign smp_vld   = vld_q[SYNC_STAGES];
  assign sclk_rise = smp_vld & sclk_s & ~sclk_prev_q;
  assign sclk_fall = smp_vld & ~sclk_s & sclk_prev_q;
  assign csn_rise  = smp_vld & csn_s & ~csn_prev_q;
  assign csn_fall  = smp_vld & ~csn_s & csn_prev_q;
  assign hdr       = {shift_q, mosi_s};

  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (hdr[6:0] == 7'(k)) rd_byte = cfg_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    sout_d     = sout_q;
    miso_d     = miso_q;
    cfg_d      = cfg_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    err_d      = 1'b0;
    if (csn_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      cnt_d   = 5'd0;
      err_d   = (cnt_q != 5'd0) && (cnt_q != 5'd16);
    end else begin
      case (state_q)
        IDLE: begin
          if (csn_fall) begin
            state_d = HDR;
            cnt_d   = 5'd0;
          end
        end
        HDR: begin
          if (sclk_rise) begin
            shift_d = {shift_q[5:0], mosi_s};
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              state_d = DATA;
              wr_d    = hdr[7];
              addr_d  = hdr[6:0];
              if (!hdr[7]) begin
                miso_d = rd_byte[7];
                sout_d = {rd_byte[6:0], 1'b0};
              end
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            shift_d = {shift_q[5:0], mosi_s};
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              state_d = DONE;
              miso_d  = 1'b0;
              for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_q && addr_q == 7'(k)) begin
                  cfg_d[k]   = hdr;
                  wr_pulse_d = 1'b1;
                  wr_addr_d  = addr_q;
                end
              end
            end
          // The fall right after the 8th rise must keep bit7 on the pin.
          end else if (sclk_fall && !wr_q && cnt_q >= 5'd9) begin
            miso_d = sout_q[7];
            sout_d = {sout_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      shift_q    <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      sout_q     <= '0;
      miso_q     <= 1'b0;
      cfg_q      <= {NUM_REGS{RESET_VAL}};
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      sout_q     <= sout_d;
      miso_q     <= miso_d;
      cfg_q      <= cfg_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = ~csn_s;
  assign cfg_o         = cfg_q;
  assign wr_pulse_o    = wr_pulse_q;
  assign wr_addr_o     = wr_addr_q;
  assign err_o         = err_q;

endmodule
